// File: rtl/spi_master.sv
// Byte-wide SPI master driven by extended ctrl codes from the bank/ctrl decoder.
// One START command shifts a full byte; RXDATA and STATUS are exposed to the bus read mux.
module spi_master #(
    parameter logic [3:0] DEV = 4'he,
    parameter int         NSS = 2
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            ctrl_stb_i,
    input  logic [15:0]     ctrl_addr_i,
    input  logic            miso_i,
    output logic            sck_o,
    output logic            mosi_o,
    output logic [NSS-1:0]  nss_o,
    output logic [7:0]      rxdata_o,
    output logic [7:0]      status_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_e;

    state_e           state_q, state_d;
    logic             sck_q, sck_d;
    logic             mosi_q, mosi_d;
    logic [NSS-1:0]   nss_q, nss_d;
    logic [7:0]       rxdata_q, rxdata_d;
    logic             ovr_q, ovr_d;
    logic             cpol_q, cpol_d;
    logic             cpha_q, cpha_d;
    logic [2:0]       div_q, div_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_q, rx_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [4:0]       tgl_q, tgl_d;

    logic             isCmd;
    logic             softRst;
    logic             busy;
    logic [7:0]       pow;
    logic [6:0]       halfLim;
    logic [4:0]       toggleNum;

    assign isCmd     = ctrl_stb_i && (ctrl_addr_i[3:2] == 2'b00) && (ctrl_addr_i[7:4] == DEV);
    // Soft reset ignores device and group bits so a wedged board can always be recovered.
    assign softRst   = ctrl_stb_i && (ctrl_addr_i[1:0] == 2'b11);
    assign busy      = (state_q != IDLE);
    assign pow       = 8'd1 << div_q;
    assign halfLim   = 7'(pow - 8'd1);
    assign toggleNum = tgl_q + 5'd1;

    always_comb begin
        state_d  = state_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        nss_d    = nss_q;
        rxdata_d = rxdata_q;
        ovr_d    = ovr_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        div_d    = div_q;
        shift_d  = shift_q;
        rx_d     = rx_q;
        cnt_d    = cnt_q;
        tgl_d    = tgl_q;

        case (state_q)
            IDLE: begin
                sck_d = cpol_q;
                if (isCmd) begin
                    case (ctrl_addr_i[1:0])
                        2'b00: begin
                            state_d = SETUP;
                            shift_d = ctrl_addr_i[15:8];
                        end
                        2'b01: begin
                            cpol_d = ctrl_addr_i[9];
                            cpha_d = ctrl_addr_i[8];
                            div_d  = ctrl_addr_i[12:10];
                            ovr_d  = 1'b0;
                        end
                        2'b10:   nss_d = ctrl_addr_i[8 +: NSS];
                        default: ;
                    endcase
                end
            end
            SETUP: begin
                sck_d   = cpol_q;
                cnt_d   = 7'd0;
                tgl_d   = 5'd0;
                rx_d    = 8'h00;
                state_d = SHIFT;
                if (!cpha_q)
                    mosi_d = shift_q[7];
            end
            SHIFT: begin
                if (cnt_q == halfLim) begin
                    cnt_d = 7'd0;
                    sck_d = ~sck_q;
                    tgl_d = toggleNum;
                    // Odd toggles lead; CPHA picks whether leading edges sample or drive.
                    if (toggleNum[0]) begin
                        if (!cpha_q) begin
                            rx_d = {rx_q[6:0], miso_i};
                        end else begin
                            mosi_d  = shift_q[7];
                            shift_d = {shift_q[6:0], 1'b0};
                        end
                    end else begin
                        if (cpha_q) begin
                            rx_d = {rx_q[6:0], miso_i};
                        end else if (toggleNum != 5'd16) begin
                            mosi_d  = shift_q[6];
                            shift_d = {shift_q[6:0], 1'b0};
                        end
                    end
                    if (toggleNum == 5'd16)
                        state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            DONE: begin
                rxdata_d = rx_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (busy && isCmd && (ctrl_addr_i[1:0] != 2'b11))
            ovr_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || softRst) begin
            state_q  <= IDLE;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b1;
            nss_q    <= '1;
            rxdata_q <= 8'h00;
            ovr_q    <= 1'b0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            div_q    <= 3'd0;
            shift_q  <= 8'h00;
            rx_q     <= 8'h00;
            cnt_q    <= 7'd0;
            tgl_q    <= 5'd0;
        end else begin
            state_q  <= state_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            nss_q    <= nss_d;
            rxdata_q <= rxdata_d;
            ovr_q    <= ovr_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            div_q    <= div_d;
            shift_q  <= shift_d;
            rx_q     <= rx_d;
            cnt_q    <= cnt_d;
            tgl_q    <= tgl_d;
        end
    end

    assign sck_o    = sck_q;
    assign mosi_o   = mosi_q;
    assign nss_o    = nss_q;
    assign rxdata_o = rxdata_q;
    assign busy_o   = busy;
    assign status_o = {busy, ovr_q, 1'b0, cpol_q, cpha_q, div_q};

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: transfers in modes 0 and 3, overrun, soft reset,
// ignored codes, and an 8-select build; inputs change and outputs are sampled on negedge.
module tb_spi_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctrlStb;
    logic [15:0] ctrlAddr;
    logic        miso;
    logic        sck;
    logic        mosi;
    logic [1:0]  nss;
    logic [7:0]  rxData;
    logic [7:0]  status;
    logic        busy;

    logic        ctrlStb8;
    logic [15:0] ctrlAddr8;
    logic        sck8;
    logic        mosi8;
    logic [7:0]  nss8;
    logic [7:0]  rxData8;
    logic [7:0]  status8;
    logic        busy8;

    logic        loopback;
    logic        slaveBit;

    int numCompared = 0;
    int numMismatched = 0;

    int          busyCycles;
    int          toggles;
    int          firstToggle;
    int          gapBad;
    logic [7:0]  risingByte;

    assign miso = loopback ? mosi : slaveBit;

    always #5 clk = ~clk;

    spi_master #(.DEV(4'he), .NSS(2)) dut (
        .clk_i(clk), .reset_i(reset), .ctrl_stb_i(ctrlStb), .ctrl_addr_i(ctrlAddr),
        .miso_i(miso), .sck_o(sck), .mosi_o(mosi), .nss_o(nss),
        .rxdata_o(rxData), .status_o(status), .busy_o(busy)
    );

    spi_master #(.DEV(4'he), .NSS(8)) dut8 (
        .clk_i(clk), .reset_i(reset), .ctrl_stb_i(ctrlStb8), .ctrl_addr_i(ctrlAddr8),
        .miso_i(1'b0), .sck_o(sck8), .mosi_o(mosi8), .nss_o(nss8),
        .rxdata_o(rxData8), .status_o(status8), .busy_o(busy8)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numCompared++;
        if (got !== exp) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; the strobe is seen by the following posedge.
    task automatic applyStimulus(input logic [15:0] addr);
        ctrlStb  = 1'b1;
        ctrlAddr = addr;
        @(negedge clk);
        ctrlStb  = 1'b0;
    endtask

    // Starts a transfer and watches it until BUSY drops, optionally injecting a
    // second command at a given cycle, and acting as a CPHA=1 slave on leading edges.
    task automatic runTransfer(input logic [15:0] startAddr, input int interruptAt,
                               input logic [15:0] intAddr, input logic [7:0] slaveByte,
                               input logic cpolExp, input int halfPeriod);
        int   idx;
        int   lastToggle;
        int   slaveIdx;
        logic prevSck;
        busyCycles  = 0;
        toggles     = 0;
        firstToggle = -1;
        gapBad      = 0;
        risingByte  = 8'h00;
        lastToggle  = 0;
        slaveIdx    = 0;
        applyStimulus(startAddr);
        prevSck = sck;
        idx = 0;
        while (busy && idx < 300) begin
            busyCycles++;
            if (idx == interruptAt) begin
                ctrlStb  = 1'b1;
                ctrlAddr = intAddr;
            end
            @(negedge clk);
            ctrlStb = 1'b0;
            idx++;
            if (sck != prevSck) begin
                toggles++;
                if (firstToggle < 0)
                    firstToggle = idx;
                else if (idx - lastToggle != halfPeriod)
                    gapBad++;
                lastToggle = idx;
                if (sck)
                    risingByte = {risingByte[6:0], mosi};
                if (sck != cpolExp && slaveIdx < 8) begin
                    slaveBit = slaveByte[7 - slaveIdx];
                    slaveIdx++;
                end
            end
            prevSck = sck;
        end
        ctrlStb = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        ctrlStb   = 1'b0;
        ctrlAddr  = 16'h0000;
        ctrlStb8  = 1'b0;
        ctrlAddr8 = 16'h0000;
        loopback  = 1'b1;
        slaveBit  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        checkOutput("reset_sck", 32'(sck), 32'h0);
        checkOutput("reset_mosi", 32'(mosi), 32'h1);
        checkOutput("reset_nss", 32'(nss), 32'h3);
        checkOutput("reset_rxdata", 32'(rxData), 32'h00);
        checkOutput("reset_status", 32'(status), 32'h00);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_nss8", 32'(nss8), 32'hFF);

        // Mode 0, DIV=0, loopback.
        applyStimulus(16'h02E2);
        checkOutput("select_nss", 32'(nss), 32'h2);
        runTransfer(16'hA5E0, -1, 16'h0000, 8'h00, 1'b0, 1);
        checkOutput("m0_busy_cycles", 32'(busyCycles), 32'd18);
        checkOutput("m0_toggles", 32'(toggles), 32'd16);
        checkOutput("m0_first_toggle", 32'(firstToggle), 32'd2);
        checkOutput("m0_gap", 32'(gapBad), 32'd0);
        checkOutput("m0_mosi_rising", 32'(risingByte), 32'hA5);
        checkOutput("m0_rxdata", 32'(rxData), 32'hA5);
        checkOutput("m0_nss", 32'(nss), 32'h2);
        checkOutput("m0_sck_idle", 32'(sck), 32'h0);

        // Mode 3, DIV=2, slave drives 8'h3C.
        applyStimulus(16'h0BE1);
        @(negedge clk);
        checkOutput("m3_sck_idle", 32'(sck), 32'h1);
        checkOutput("m3_status_cfg", 32'(status), 32'h1A);
        loopback = 1'b0;
        runTransfer(16'h5AE0, -1, 16'h0000, 8'h3C, 1'b1, 4);
        loopback = 1'b1;
        checkOutput("m3_busy_cycles", 32'(busyCycles), 32'd66);
        checkOutput("m3_toggles", 32'(toggles), 32'd16);
        checkOutput("m3_first_toggle", 32'(firstToggle), 32'd5);
        checkOutput("m3_gap", 32'(gapBad), 32'd0);
        checkOutput("m3_mosi_rising", 32'(risingByte), 32'h5A);
        checkOutput("m3_rxdata", 32'(rxData), 32'h3C);
        checkOutput("m3_sck_after", 32'(sck), 32'h1);
        checkOutput("m3_status_after", 32'(status), 32'h1A);

        // Back to mode 0, DIV=0; START while busy must be rejected and flag OVR.
        applyStimulus(16'h00E1);
        checkOutput("cfg0_status", 32'(status), 32'h00);
        runTransfer(16'h01E0, 4, 16'hFFE0, 8'h00, 1'b0, 1);
        checkOutput("ovr_busy_cycles", 32'(busyCycles), 32'd18);
        checkOutput("ovr_mosi_rising", 32'(risingByte), 32'h01);
        checkOutput("ovr_rxdata", 32'(rxData), 32'h01);
        checkOutput("ovr_status", 32'(status), 32'h40);
        applyStimulus(16'h00E1);
        checkOutput("ovr_cleared", 32'(status), 32'h00);

        // START arriving on the DONE edge.
        runTransfer(16'h96E0, 17, 16'h33E0, 8'h00, 1'b0, 1);
        checkOutput("done_busy_cycles", 32'(busyCycles), 32'd18);
        checkOutput("done_rxdata", 32'(rxData), 32'h96);
        checkOutput("done_ovr_status", 32'(status), 32'h40);
        @(negedge clk);
        checkOutput("done_no_restart", 32'(busy), 32'h0);
        applyStimulus(16'h00E1);

        // Codes that must be ignored.
        applyStimulus(16'h00D0);
        checkOutput("ign_dev_busy", 32'(busy), 32'h0);
        applyStimulus(16'h00D2);
        checkOutput("ign_dev_nss", 32'(nss), 32'h2);
        applyStimulus(16'h00E4);
        checkOutput("ign_grp_busy", 32'(busy), 32'h0);
        applyStimulus(16'h00E6);
        checkOutput("ign_grp_nss", 32'(nss), 32'h2);
        checkOutput("ign_status", 32'(status), 32'h00);

        // Soft reset at cycle 9 of a DIV=0 transfer.
        runTransfer(16'hC3E0, 8, 16'h00E3, 8'h00, 1'b0, 1);
        checkOutput("srst_busy_cycles", 32'(busyCycles), 32'd9);
        checkOutput("srst_sck", 32'(sck), 32'h0);
        checkOutput("srst_mosi", 32'(mosi), 32'h1);
        checkOutput("srst_nss", 32'(nss), 32'h3);
        checkOutput("srst_rxdata", 32'(rxData), 32'h00);
        checkOutput("srst_status", 32'(status), 32'h00);

        // Eight chip selects.
        ctrlStb8  = 1'b1;
        ctrlAddr8 = 16'h7FE2;
        @(negedge clk);
        ctrlStb8  = 1'b0;
        checkOutput("nss8_select", 32'(nss8), 32'h7F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
